// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC -> sync imem, 2-entry {instr,pc} buffer to decode; PC issued in n is valid in n+2.
// Backpressure holds the PC via PcLoadEnable; Flush redirects. FETCH_PERF_EN adds Fetch/Stall counters.
module instruction_fetch_stage #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned INSTR_W = 16
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [ADDR_W-1:0]  CounterValue,
   output logic [ADDR_W-1:0]  MemAddress,
   output logic               MemRead,
   input  logic [INSTR_W-1:0] MemData,
   output logic [ADDR_W-1:0]  PcLoadValue,
   output logic               PcLoadEnable,
   input  logic               Flush,
   input  logic [ADDR_W-1:0]  BranchTarget,
   output logic [INSTR_W-1:0] InstrOut,
   output logic [ADDR_W-1:0]  InstrPC,
   output logic               InstrValid,
   input  logic               InstrReady
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        FetchCount,
   output logic [31:0]        StallCount
`endif
);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   entry_t            head_q;
   entry_t            tail_q;
   logic [1:0]        occ_q;
   logic              in_flight_q;
   logic [ADDR_W-1:0] in_flight_pc_q;

   logic              pop;
   logic              capture;
   logic              issue;
   logic [2:0]        level;
   entry_t            new_entry;

   assign InstrValid = (occ_q != 2'd0);
   assign InstrOut   = head_q.instr;
   assign InstrPC    = head_q.pc;
   assign MemAddress = CounterValue;

   assign pop       = InstrValid & InstrReady;
   assign capture   = in_flight_q & ~Flush;
   assign new_entry = '{instr: MemData, pc: in_flight_pc_q};

   // Slots committed after this cycle; pop only happens with occ>0 so no underflow.
   assign level   = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
   assign issue   = ~Reset & ~Flush & (level < 3'd2);
   assign MemRead = issue;

   always_comb begin
      PcLoadEnable = 1'b0;
      PcLoadValue  = CounterValue;
      if (!Reset) begin
         if (Flush) begin
            PcLoadEnable = 1'b1;
            PcLoadValue  = BranchTarget;
         end else if (!issue) begin
            PcLoadEnable = 1'b1;
         end
      end
   end

   // An issue always produces a response next cycle, otherwise it is captured or dropped.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         in_flight_q    <= 1'b0;
         in_flight_pc_q <= '0;
      end else begin
         in_flight_q <= issue;
         if (issue) begin
            in_flight_pc_q <= CounterValue;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else if (Flush) begin
         occ_q <= 2'd0;
      end else begin
         unique case ({pop, capture})
            2'b10: begin
               head_q <= tail_q;
               occ_q  <= occ_q - 2'd1;
            end
            2'b01: begin
               if (occ_q == 2'd0) begin
                  head_q <= new_entry;
               end else begin
                  tail_q <= new_entry;
               end
               occ_q <= occ_q + 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  head_q <= new_entry;
               end else begin
                  head_q <= tail_q;
                  tail_q <= new_entry;
               end
            end
            default: begin
               occ_q <= occ_q;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge Clock) begin
      if (Reset) begin
         FetchCount <= '0;
         StallCount <= '0;
      end else begin
         if (issue && (FetchCount != 32'hFFFF_FFFF)) begin
            FetchCount <= FetchCount + 32'd1;
         end
         if (InstrValid && !InstrReady && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: PC and imem models, directed stimulus, in-order scoreboard.
module tb_instruction_fetch_stage;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] CounterValue;
   logic [15:0] MemAddress;
   logic        MemRead;
   logic [15:0] MemData = 16'h0;
   logic [15:0] PcLoadValue;
   logic        PcLoadEnable;
   logic        Flush;
   logic [15:0] BranchTarget;
   logic [15:0] InstrOut;
   logic [15:0] InstrPC;
   logic        InstrValid;
   logic        InstrReady;
`ifdef FETCH_PERF_EN
   logic [31:0] FetchCount;
   logic [31:0] StallCount;
`endif

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_memread = 0;
   logic [15:0] pc_reg = 16'h0;

   instruction_fetch_stage #(.ADDR_W(16), .INSTR_W(16)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .CounterValue (CounterValue),
      .MemAddress   (MemAddress),
      .MemRead      (MemRead),
      .MemData      (MemData),
      .PcLoadValue  (PcLoadValue),
      .PcLoadEnable (PcLoadEnable),
      .Flush        (Flush),
      .BranchTarget (BranchTarget),
      .InstrOut     (InstrOut),
      .InstrPC      (InstrPC),
      .InstrValid   (InstrValid),
      .InstrReady   (InstrReady)
`ifdef FETCH_PERF_EN
      ,
      .FetchCount   (FetchCount),
      .StallCount   (StallCount)
`endif
   );

   always #5 Clock = ~Clock;

   // Program counter: reset to 0, load, or self-increment.
   assign CounterValue = pc_reg;
   always @(posedge Clock) begin
      if (Reset)             pc_reg <= 16'h0;
      else if (PcLoadEnable) pc_reg <= PcLoadValue;
      else                   pc_reg <= pc_reg + 16'h1;
   end

   // Instruction memory: mem[a] = 0x1000 + a, one-cycle read.
   always @(posedge Clock) begin
      if (MemRead) MemData <= 16'h1000 + MemAddress;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_seq(input logic [15:0] start, input int n);
      exp_t e;
      logic [15:0] a;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         a = start + 16'(i);
         e.pc = a;
         e.instr = 16'h1000 + a;
         exp_q.push_back(e);
      end
   endtask

   task automatic cyc(input logic rdy, input logic fl, input logic [15:0] tgt, input logic rst);
      @(posedge Clock);
      #1;
      InstrReady = rdy;
      Flush = fl;
      BranchTarget = tgt;
      Reset = rst;
      #1;
   endtask

   // Monitor: every accepted head must match the next expected entry.
   always @(negedge Clock) begin
      exp_t e;
      if (!Reset && MemRead) n_memread++;
      if (!Reset && !Flush && InstrValid && InstrReady) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected: got pc %h instr %h, expected nothing", InstrPC, InstrOut);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc", 32'(InstrPC), 32'(e.pc));
            chk("sb_instr", 32'(InstrOut), 32'(e.instr));
         end
      end
   end

   initial begin
      Reset = 1'b1;
      Flush = 1'b0;
      BranchTarget = 16'h0;
      InstrReady = 1'b1;

      // Reset state
      cyc(1, 0, 16'h0, 1);
      chk("rst_valid", 32'(InstrValid), 0);
      chk("rst_instr", 32'(InstrOut), 0);
      chk("rst_pc", 32'(InstrPC), 0);
      chk("rst_memread", 32'(MemRead), 0);
      chk("rst_ple", 32'(PcLoadEnable), 0);

      // Streaming from PC 0
      cyc(1, 0, 16'h0, 0);
      push_seq(16'h0000, 64);
      chk("c0_valid", 32'(InstrValid), 0);
      chk("c0_memread", 32'(MemRead), 1);
      chk("c0_ple", 32'(PcLoadEnable), 0);
      cyc(1, 0, 16'h0, 0);
      chk("c1_valid", 32'(InstrValid), 0);
      chk("c1_ple", 32'(PcLoadEnable), 0);
      cyc(1, 0, 16'h0, 0);
      chk("c2_valid", 32'(InstrValid), 1);
      chk("c2_pc", 32'(InstrPC), 0);
      chk("c2_instr", 32'(InstrOut), 32'h1000);
      chk("c2_ple", 32'(PcLoadEnable), 0);
      for (int i = 3; i <= 5; i++) begin
         cyc(1, 0, 16'h0, 0);
         chk("stream_ple", 32'(PcLoadEnable), 0);
         chk("stream_memread", 32'(MemRead), 1);
      end

      // Decode stall for three cycles with head PC 4
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 16'h0, 0);
         chk("stall_instr", 32'(InstrOut), 32'h1004);
         chk("stall_pc", 32'(InstrPC), 4);
         chk("stall_memread", 32'(MemRead), 0);
         chk("stall_ple", 32'(PcLoadEnable), 1);
         chk("stall_plv", 32'(PcLoadValue), 6);
      end
      cyc(1, 0, 16'h0, 0);
      chk("release_pc", 32'(InstrPC), 4);
      chk("release_memread", 32'(MemRead), 1);
      chk("release_ple", 32'(PcLoadEnable), 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0, 0);
`ifdef FETCH_PERF_EN
      chk("perf_stall", StallCount, 3);
      chk("perf_fetch", FetchCount, 32'(n_memread));
`endif

      // Flush while buffer is full
      cyc(0, 0, 16'h0, 0);
      chk("fill_memread", 32'(MemRead), 0);
      cyc(0, 1, 16'h00F0, 0);
      push_seq(16'h00F0, 32);
      chk("fl_full_valid", 32'(InstrValid), 1);
      chk("fl_full_ple", 32'(PcLoadEnable), 1);
      chk("fl_full_plv", 32'(PcLoadValue), 32'h00F0);
      chk("fl_full_memread", 32'(MemRead), 0);
      cyc(1, 0, 16'h0, 0);
      chk("fl_next_valid", 32'(InstrValid), 0);
      chk("fl_next_memread", 32'(MemRead), 1);
      chk("fl_next_ple", 32'(PcLoadEnable), 0);
      cyc(1, 0, 16'h0, 0);
      chk("fl_gap_valid", 32'(InstrValid), 0);
      cyc(1, 0, 16'h0, 0);
      chk("fl_first_valid", 32'(InstrValid), 1);
      chk("fl_first_pc", 32'(InstrPC), 32'h00F0);
      chk("fl_first_instr", 32'(InstrOut), 32'h10F0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0, 0);

      // Flush together with a ready head
      cyc(1, 1, 16'h0040, 0);
      push_seq(16'h0040, 32);
      chk("flr_valid", 32'(InstrValid), 1);
      chk("flr_ple", 32'(PcLoadEnable), 1);
      chk("flr_plv", 32'(PcLoadValue), 32'h0040);
      chk("flr_memread", 32'(MemRead), 0);
      cyc(1, 0, 16'h0, 0);
      chk("flr_empty", 32'(InstrValid), 0);
      cyc(1, 0, 16'h0, 0);
      chk("flr_gap", 32'(InstrValid), 0);
      cyc(1, 0, 16'h0, 0);
      chk("flr_first_pc", 32'(InstrPC), 32'h0040);
      chk("flr_first_instr", 32'(InstrOut), 32'h1040);
      for (int i = 0; i < 2; i++) cyc(1, 0, 16'h0, 0);

      // PC wrap through 0xFFFF
      cyc(1, 1, 16'hFFFE, 0);
      push_seq(16'hFFFE, 32);
      cyc(1, 0, 16'h0, 0);
      cyc(1, 0, 16'h0, 0);
      cyc(1, 0, 16'h0, 0);
      chk("wrap_pc0", 32'(InstrPC), 32'hFFFE);
      chk("wrap_instr0", 32'(InstrOut), 32'h0FFE);
      cyc(1, 0, 16'h0, 0);
      chk("wrap_pc1", 32'(InstrPC), 32'hFFFF);
      cyc(1, 0, 16'h0, 0);
      chk("wrap_pc2", 32'(InstrPC), 32'h0000);
      chk("wrap_instr2", 32'(InstrOut), 32'h1000);
      for (int i = 0; i < 6; i++) cyc(1, 0, 16'h0, 0);

      // Reset mid-stream, with Flush also raised
      cyc(1, 1, 16'h0123, 1);
      push_seq(16'h0000, 32);
      chk("mrst_memread", 32'(MemRead), 0);
      chk("mrst_ple", 32'(PcLoadEnable), 0);
      cyc(1, 0, 16'h0, 0);
      chk("mrst_valid", 32'(InstrValid), 0);
      chk("mrst_instr", 32'(InstrOut), 0);
      chk("mrst_pc", 32'(InstrPC), 0);
      chk("mrst_memread_rel", 32'(MemRead), 1);
      chk("mrst_counter", 32'(CounterValue), 0);
`ifdef FETCH_PERF_EN
      chk("perf_fetch_rst", FetchCount, 0);
      chk("perf_stall_rst", StallCount, 0);
`endif
      cyc(1, 0, 16'h0, 0);
      chk("mrst_gap", 32'(InstrValid), 0);
      cyc(1, 0, 16'h0, 0);
      chk("mrst_first_valid", 32'(InstrValid), 1);
      chk("mrst_first_pc", 32'(InstrPC), 0);
      chk("mrst_first_instr", 32'(InstrOut), 32'h1000);
      for (int i = 0; i < 6; i++) cyc(1, 0, 16'h0, 0);

      @(posedge Clock);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
